// File: rtl/niq_dispatch.sv
// Pops one descriptor at a time from the input-queue FIFO and presents it to a wr/ack consumer.
// Latency: wr rises two cycles after the read strobe; backpressure: wr is held until ack or TIMEOUT_CYCLES, then the descriptor is dropped.
module niq_dispatch #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [56:0] iv_fifo_rdata,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd,
    output logic [47:0] ov_tsntag,
    output logic [8:0]  ov_bufid,
    output logic        o_descriptor_wr,
    input  logic        i_descriptor_ack,
    output logic [15:0] ov_dispatch_cnt,
    output logic [15:0] ov_timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE_S    = 3'd0,
        READ_S    = 3'd1,
        LATCH_S   = 3'd2,
        SEND_S    = 3'd3,
        RELEASE_S = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_nxt;
    logic        rd_nxt;
    logic        wr_nxt;
    logic [47:0] tag_nxt;
    logic [8:0]  bufid_nxt;
    logic [15:0] disp_nxt;
    logic [15:0] to_nxt;
    logic        tmo_expired;

    // tmo_cnt counts completed wr-high cycles, so this is true in the last allowed cycle.
    assign tmo_expired = ({1'b0, tmo_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE_S;
            tmo_cnt         <= 16'd0;
            o_fifo_rd       <= 1'b0;
            o_descriptor_wr <= 1'b0;
            ov_tsntag       <= 48'd0;
            ov_bufid        <= 9'd0;
            ov_dispatch_cnt <= 16'd0;
            ov_timeout_cnt  <= 16'd0;
        end else begin
            state           <= state_nxt;
            tmo_cnt         <= tmo_nxt;
            o_fifo_rd       <= rd_nxt;
            o_descriptor_wr <= wr_nxt;
            ov_tsntag       <= tag_nxt;
            ov_bufid        <= bufid_nxt;
            ov_dispatch_cnt <= disp_nxt;
            ov_timeout_cnt  <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE_S;
        tmo_nxt   = tmo_cnt;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        tag_nxt   = ov_tsntag;
        bufid_nxt = ov_bufid;
        disp_nxt  = ov_dispatch_cnt;
        to_nxt    = ov_timeout_cnt;
        case (state)
            IDLE_S: begin
                if (!i_fifo_empty) begin
                    rd_nxt    = 1'b1;
                    state_nxt = READ_S;
                end
            end
            READ_S: begin
                state_nxt = LATCH_S;
            end
            LATCH_S: begin
                tag_nxt   = iv_fifo_rdata[56:9];
                bufid_nxt = iv_fifo_rdata[8:0];
                wr_nxt    = 1'b1;
                tmo_nxt   = 16'd0;
                state_nxt = SEND_S;
            end
            SEND_S: begin
                // Ack is checked first so an ack in the expiry cycle counts as a dispatch.
                if (i_descriptor_ack) begin
                    disp_nxt  = ov_dispatch_cnt + 16'd1;
                    tag_nxt   = 48'd0;
                    bufid_nxt = 9'd0;
                    state_nxt = RELEASE_S;
                end else if (tmo_expired) begin
                    to_nxt    = ov_timeout_cnt + 16'd1;
                    tag_nxt   = 48'd0;
                    bufid_nxt = 9'd0;
                    state_nxt = RELEASE_S;
                end else begin
                    wr_nxt    = 1'b1;
                    tmo_nxt   = tmo_cnt + 16'd1;
                    state_nxt = SEND_S;
                end
            end
            RELEASE_S: begin
                tag_nxt   = 48'd0;
                bufid_nxt = 9'd0;
                state_nxt = IDLE_S;
            end
            default: begin
                state_nxt = IDLE_S;
            end
        endcase
    end

endmodule
